// File: rtl/led_pattern_engine.sv
// LED pattern engine: one prescaler and one pattern register drive four animated patterns.
// Optional macro LED_BOUNCE_EN turns mode 11 into a bouncing dot; otherwise mode 11 blinks the whole bank.
module led_pattern_engine #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_FILL = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic             load_pending_q, load_pending_d;

  logic             reload;
  logic             tick;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] advance;

`ifdef LED_BOUNCE_EN
  logic dir_q, dir_d;
  logic dir_adv;
`endif

  // Seed for the incoming mode, taken straight from S so a reload edge lands on it.
  always_comb begin
    seed = '0;
    case (mode_e'(S))
      MODE_ROL:  seed = {{(WIDTH-1){1'b0}}, 1'b1};
      MODE_ROR:  seed = {1'b1, {(WIDTH-1){1'b0}}};
      MODE_FILL: seed = '0;
`ifdef LED_BOUNCE_EN
      MODE_ALT:  seed = {{(WIDTH-1){1'b0}}, 1'b1};
`else
      MODE_ALT:  seed = '0;
`endif
      default:   seed = '0;
    endcase
  end

  // Next pattern value for the accepted mode; only consulted on a tick without reload.
  always_comb begin
    advance = led_q;
`ifdef LED_BOUNCE_EN
    dir_adv = dir_q;
`endif
    case (mode_e'(s_q))
      MODE_ROL:  advance = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      MODE_ROR:  advance = {led_q[0], led_q[WIDTH-1:1]};
      MODE_FILL: begin
        if (led_q == ALL_ONES) begin
          advance = '0;
        end else begin
          advance = {led_q[WIDTH-2:0], 1'b1};
        end
      end
`ifdef LED_BOUNCE_EN
      MODE_ALT: begin
        if (!dir_q) begin
          advance = {led_q[WIDTH-2:0], 1'b0};
          if (advance[WIDTH-1]) begin
            dir_adv = 1'b1;
          end
        end else begin
          advance = {1'b0, led_q[WIDTH-1:1]};
          if (advance[0]) begin
            dir_adv = 1'b0;
          end
        end
      end
`else
      MODE_ALT:  advance = ~led_q;
`endif
      default:   advance = led_q;
    endcase
  end

  always_comb begin
    reload         = load_pending_q || (S != s_q);
    tick           = (cnt_q == CNT_LAST);
    cnt_d          = cnt_q + CNT_ONE;
    s_d            = s_q;
    led_d          = led_q;
    step_d         = 1'b0;
    load_pending_d = load_pending_q;
`ifdef LED_BOUNCE_EN
    dir_d          = dir_q;
`endif
    if (reload) begin
      // A reload wins over a coincident tick: restart the pattern and the prescaler phase.
      led_d          = seed;
      s_d            = S;
      cnt_d          = '0;
      load_pending_d = 1'b0;
`ifdef LED_BOUNCE_EN
      dir_d          = 1'b0;
`endif
    end else if (tick) begin
      cnt_d  = '0;
      led_d  = advance;
      step_d = 1'b1;
`ifdef LED_BOUNCE_EN
      dir_d  = dir_adv;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      s_q            <= 2'b00;
      led_q          <= '0;
      step_q         <= 1'b0;
      load_pending_q <= 1'b1;
    end else begin
      cnt_q          <= cnt_d;
      s_q            <= s_d;
      led_q          <= led_d;
      step_q         <= step_d;
      load_pending_q <= load_pending_d;
    end
  end

`ifdef LED_BOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: an 8-bit/DIV=4 instance and a 4-bit/DIV=1 instance.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s8, s4;
  logic [7:0] led8;
  logic [3:0] led4;
  logic       step8, step4;

  int checks = 0;
  int errors = 0;

  led_pattern_engine #(.WIDTH(8), .DIV(4)) dut8 (
    .clk(clk), .rst(rst), .S(s8), .led(led8), .step(step8)
  );

  led_pattern_engine #(.WIDTH(4), .DIV(1)) dut4 (
    .clk(clk), .rst(rst), .S(s4), .led(led4), .step(step4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: per instance, mode, steps since reload and prescaler phase.
  int m_w[2]    = '{8, 4};
  int m_d[2]    = '{4, 1};
  int m_mode[2];
  int m_k[2];
  int m_ph[2];
  bit m_pend[2];
  bit m_step[2];

  function automatic int unsigned pattern(int w, int mode, int k);
    int unsigned all;
    int p;
    int pos;
    all = (32'd1 << w) - 1;
    case (mode)
      0: pattern = 32'd1 << (k % w);
      1: pattern = 32'd1 << (w - 1 - (k % w));
      2: pattern = (32'd1 << (k % (w + 1))) - 1;
      default: begin
`ifdef LED_BOUNCE_EN
        p   = k % (2 * w - 2);
        pos = (p < w) ? p : (2 * w - 2 - p);
        pattern = 32'd1 << pos;
`else
        p   = 0;
        pos = 0;
        pattern = (k % 2 == 1) ? all : 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic int unsigned exp_led(int i);
    if (m_pend[i]) return 0;
    return pattern(m_w[i], m_mode[i], m_k[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_k[i] = 0; m_ph[i] = 0; m_pend[i] = 1'b1; m_step[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input int s);
    if (m_pend[i] || s != m_mode[i]) begin
      m_mode[i] = s; m_k[i] = 0; m_ph[i] = 0; m_pend[i] = 1'b0; m_step[i] = 1'b0;
    end else if (m_ph[i] == m_d[i] - 1) begin
      m_ph[i] = 0; m_k[i] = m_k[i] + 1; m_step[i] = 1'b1;
    end else begin
      m_ph[i] = m_ph[i] + 1; m_step[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge(0, int'(s8));
    model_edge(1, int'(s4));
    @(negedge clk);
    chk("model_led8", led8, exp_led(0));
    chk("model_step8", step8, m_step[0]);
    chk("model_led4", led4, exp_led(1));
    chk("model_step4", step4, m_step[1]);
  endtask

  typedef struct {
    logic [1:0] s8;
    logic [7:0] led8;
    logic       step8;
    logic [3:0] led4;
  } vec_t;

  vec_t vecs[16];
  logic [7:0] seq11[16];

  initial begin
    vecs[0]  = '{2'b00, 8'h01, 1'b0, 4'h1};
    vecs[1]  = '{2'b00, 8'h01, 1'b0, 4'h2};
    vecs[2]  = '{2'b00, 8'h01, 1'b0, 4'h4};
    vecs[3]  = '{2'b00, 8'h01, 1'b0, 4'h8};
    vecs[4]  = '{2'b00, 8'h02, 1'b1, 4'h1};
    vecs[5]  = '{2'b00, 8'h02, 1'b0, 4'h2};
    vecs[6]  = '{2'b00, 8'h02, 1'b0, 4'h4};
    vecs[7]  = '{2'b00, 8'h02, 1'b0, 4'h8};
    vecs[8]  = '{2'b00, 8'h04, 1'b1, 4'h1};
    vecs[9]  = '{2'b00, 8'h04, 1'b0, 4'h2};
    vecs[10] = '{2'b00, 8'h04, 1'b0, 4'h4};
    vecs[11] = '{2'b01, 8'h80, 1'b0, 4'h8};
    vecs[12] = '{2'b01, 8'h80, 1'b0, 4'h1};
    vecs[13] = '{2'b01, 8'h80, 1'b0, 4'h2};
    vecs[14] = '{2'b01, 8'h80, 1'b0, 4'h4};
    vecs[15] = '{2'b01, 8'h40, 1'b1, 4'h8};
`ifdef LED_BOUNCE_EN
    seq11 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
    seq11 = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF,
              8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
`endif

    rst = 1'b1; s8 = 2'b00; s4 = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_led8", led8, 0);
    chk("reset_step8", step8, 0);
    chk("reset_led4", led4, 0);
    rst = 1'b0;

    // Release, rotate-left progression, then a mid-count switch to rotate-right.
    for (int i = 0; i < 16; i++) begin
      s8 = vecs[i].s8;
      cycle();
      chk($sformatf("vec%0d_led8", i), led8, vecs[i].led8);
      chk($sformatf("vec%0d_step8", i), step8, vecs[i].step8);
      chk($sformatf("vec%0d_led4", i), led4, vecs[i].led4);
    end

    // Progressive fill: 00, 01, 03 ... FF, 00 at four-cycle spacing.
    s8 = 2'b10;
    cycle();
    chk("fill_seed", led8, 8'h00);
    chk("fill_seed_step", step8, 0);
    for (int j = 1; j <= 9; j++) begin
      repeat (4) cycle();
      chk($sformatf("fill_step%0d", j), led8, (j <= 8) ? ((32'd1 << j) - 1) : 0);
    end

    // Mode 11 sequence.
    s8 = 2'b11;
    cycle();
    chk("m11_seed", led8, seq11[0]);
    for (int j = 1; j < 16; j++) begin
      repeat (4) cycle();
      chk($sformatf("m11_step%0d", j), led8, seq11[j]);
    end

    // Asynchronous reset while led = 10, then reload to the current mode's seed.
    s8 = 2'b00;
    cycle();
    repeat (16) cycle();
    chk("pre_rst_led8", led8, 8'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led8", led8, 0);
    chk("async_rst_step8", step8, 0);
    chk("async_rst_led4", led4, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    s8 = 2'b01;
    rst = 1'b0;
    cycle();
    chk("post_rst_seed", led8, 8'h80);

    // Randomised mode changes against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) s8 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) s4 = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
